// File: rtl/irq_ctrl.sv
// Interrupt collector: edge-detects eight event lines, latches them as pending,
// masks them onto int_out and holds the output off for a while after each ack.
module irq_ctrl #(
  parameter logic [15:0] HOLDOFF = 16'd256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] src_event,
  input  logic       mask_we,
  input  logic [7:0] mask_data,
  input  logic [7:0] int_ack,
  output logic [7:0] int_out,
  output logic [7:0] overflow,
  output logic       active
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [7:0]  src_d_reg;
  logic [7:0]  pending_reg, pending_next;
  logic [7:0]  overflow_reg, overflow_next;
  logic [7:0]  mask_reg, mask_next;
  logic [7:0]  rise;
  logic [7:0]  pm_cur, pm_next;

  assign rise = src_event & ~src_d_reg;

  // A new event wins over a same-cycle ack for pending; an ack wins for overflow.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign pending_next[gi]  = rise[gi] | (pending_reg[gi] & ~int_ack[gi]);
      assign overflow_next[gi] = ~int_ack[gi] &
                                 (overflow_reg[gi] | (rise[gi] & pending_reg[gi]));
    end
  endgenerate

  assign mask_next = mask_we ? mask_data : mask_reg;
  assign pm_cur    = pending_reg & mask_reg;
  assign pm_next   = pending_next & mask_next;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE, S_ACTIVE: begin
        if ((int_ack != 8'h00) && (HOLDOFF != 16'd0)) begin
          state_next = S_HOLD;
          count_next = HOLDOFF - 16'd1;
        end else begin
          state_next = (pm_cur != 8'h00) ? S_ACTIVE : S_IDLE;
        end
      end
      S_HOLD: begin
        // Leaving hold-off looks at the vector as it will be after this edge.
        if (count_reg == 16'd0) begin
          state_next = (pm_next != 8'h00) ? S_ACTIVE : S_IDLE;
        end else begin
          count_next = count_reg - 16'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= 16'd0;
      src_d_reg    <= 8'h00;
      pending_reg  <= 8'h00;
      overflow_reg <= 8'h00;
      mask_reg     <= 8'hFF;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      src_d_reg    <= src_event;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      mask_reg     <= mask_next;
    end
  end

  assign int_out  = (state_reg == S_HOLD) ? 8'h00 : pm_cur;
  assign overflow = overflow_reg;
  assign active   = (state_reg == S_ACTIVE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table followed by randomized traffic
// checked against a behavioural model of pending bits and hold-off time.
module tb_irq_ctrl;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_event;
  logic       mask_we;
  logic [7:0] mask_data;
  logic [7:0] int_ack;
  logic [7:0] int_out;
  logic [7:0] overflow;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.HOLDOFF(16'(HOLD))) dut (
    .clk       (clk),
    .reset     (reset),
    .src_event (src_event),
    .mask_we   (mask_we),
    .mask_data (mask_data),
    .int_ack   (int_ack),
    .int_out   (int_out),
    .overflow  (overflow),
    .active    (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] ev;
    logic [7:0] ack;
    logic       mwe;
    logic [7:0] mdata;
    logic [7:0] exp_out;
    logic [7:0] exp_ovf;
    logic       exp_act;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: bit sets plus a count of remaining silent cycles.
  logic [7:0] m_prev = 8'h00, m_pend = 8'h00, m_ovf = 8'h00, m_msk = 8'hFF;
  int         m_hold = 0;
  logic       m_act  = 1'b0;

  task automatic model_edge(input logic rst, input logic [7:0] ev, input logic [7:0] ack,
                            input logic mwe, input logic [7:0] mdata);
    logic [7:0] rise, new_pend, new_ovf, new_msk, old_vis;
    if (rst) begin
      m_prev = 8'h00; m_pend = 8'h00; m_ovf = 8'h00; m_msk = 8'hFF;
      m_hold = 0; m_act = 1'b0;
      return;
    end
    rise     = ev & ~m_prev;
    old_vis  = m_pend & m_msk;
    new_pend = (m_pend & ~ack) | rise;
    new_ovf  = (m_ovf | (rise & m_pend)) & ~ack;
    new_msk  = mwe ? mdata : m_msk;
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
      m_act  = (m_hold == 0) && ((new_pend & new_msk) != 8'h00);
    end else if (ack != 8'h00 && HOLD > 0) begin
      m_hold = HOLD;
      m_act  = 1'b0;
    end else begin
      m_act = (old_vis != 8'h00);
    end
    m_prev = ev; m_pend = new_pend; m_ovf = new_ovf; m_msk = new_msk;
  endtask

  function automatic logic [7:0] model_out();
    return (m_hold > 0) ? 8'h00 : (m_pend & m_msk);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %02h, expected %02h", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] ev, input logic [7:0] ack,
                       input logic mwe, input logic [7:0] mdata);
    reset = rst; src_event = ev; int_ack = ack; mask_we = mwe; mask_data = mdata;
    @(posedge clk);
    model_edge(rst, ev, ack, mwe, mdata);
    #1;
  endtask

  task automatic add(input logic rst, input logic [7:0] ev, input logic [7:0] ack,
                     input logic mwe, input logic [7:0] mdata, input logic [7:0] eo,
                     input logic [7:0] ef, input logic ea);
    vec_t v;
    v.rst = rst; v.ev = ev; v.ack = ack; v.mwe = mwe; v.mdata = mdata;
    v.exp_out = eo; v.exp_ovf = ef; v.exp_act = ea;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; src_event = 8'h00; int_ack = 8'h00; mask_we = 1'b0; mask_data = 8'h00;

    // rst, ev, ack, mwe, mdata | int_out, overflow, active (after the edge)
    add(1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);  // reset state
    add(0, 8'h04, 8'h00, 0, 8'h00, 8'h04, 8'h00, 0);  // one-cycle pulse
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h04, 8'h00, 1);
    add(0, 8'h00, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0);  // ack: 4 silent cycles
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);  // back to idle
    add(0, 8'h02, 8'h00, 0, 8'h00, 8'h02, 8'h00, 0);
    add(0, 8'h00, 8'h02, 0, 8'h00, 8'h00, 8'h00, 0);  // ack, then event in hold-off
    add(0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1);  // 5th cycle: visible
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1);
    add(0, 8'h80, 8'h00, 0, 8'h00, 8'h81, 8'h00, 1);  // bit 7 twice
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h81, 8'h00, 1);
    add(0, 8'h80, 8'h00, 0, 8'h00, 8'h81, 8'h80, 1);
    add(0, 8'h00, 8'h81, 0, 8'h00, 8'h00, 8'h00, 0);  // ack clears overflow
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h08, 8'h00, 0, 8'h00, 8'h08, 8'h00, 0);  // bit 3 pending
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h08, 8'h00, 1);
    add(0, 8'h08, 8'h08, 0, 8'h00, 8'h00, 8'h00, 0);  // rise and ack together
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h08, 8'h00, 1);
    add(0, 8'h00, 8'h08, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);  // mask all off
    add(0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h00, 8'h00, 1, 8'hFF, 8'h10, 8'h00, 0);  // unmask shows pending
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h10, 8'h00, 1);
    add(0, 8'hF0, 8'h00, 0, 8'h00, 8'hF0, 8'h10, 1);
    add(0, 8'h00, 8'h01, 0, 8'h00, 8'h00, 8'h10, 0);  // into hold-off
    add(1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);  // reset mid hold-off
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    add(0, 8'h20, 8'h00, 0, 8'h00, 8'h20, 8'h00, 0);
    add(0, 8'h00, 8'h00, 0, 8'h00, 8'h20, 8'h00, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ev, tbl[i].ack, tbl[i].mwe, tbl[i].mdata);
      check("vec_int_out", i, int_out, tbl[i].exp_out);
      check("vec_overflow", i, overflow, tbl[i].exp_ovf);
      check("vec_active", i, {7'd0, active}, {7'd0, tbl[i].exp_act});
    end

    // Line already high at reset release yields exactly one event.
    drive(0, 8'h40, 8'h00, 0, 8'h00);
    drive(1, 8'h40, 8'h00, 0, 8'h00);
    drive(0, 8'h40, 8'h00, 0, 8'h00);
    check("held_line_event", 0, int_out, 8'h40);
    drive(0, 8'h40, 8'h00, 0, 8'h00);
    check("held_line_no_ovf", 0, overflow, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_mwe;
      logic [7:0] r_ev, r_ack, r_md;
      r_rst = ($urandom_range(0, 199) == 0);
      r_ev  = src_event ^ (8'($urandom) & 8'($urandom));
      r_ack = ($urandom_range(0, 3) == 0) ? (8'($urandom) & (m_pend | 8'($urandom))) : 8'h00;
      r_mwe = ($urandom_range(0, 19) == 0);
      r_md  = 8'($urandom);
      drive(r_rst, r_ev, r_ack, r_mwe, r_md);
      check("rnd_int_out", i, int_out, model_out());
      check("rnd_overflow", i, overflow, m_ovf);
      check("rnd_active", i, {7'd0, active}, {7'd0, m_act});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt collector that sits between the core's event sources (HID, floppy, SD card, etc.) and the MCU control interface. It edge-detects up to eight event lines, latches them as pending, and applies a per-source enable mask. It drives the resulting vector into the control interface's `int_in` and clears bits on the `int_ack` pulse returned from there. A hold-off timer after every acknowledge keeps a stormy source from re-asserting the MCU interrupt line back-to-back.

## Interface
- `HOLDOFF`, default 16'd256: cycles `int_out` is forced to zero after an acknowledge; 0 disables hold-off; legal range 0..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `src_event`  in  8  event lines, one per source; rising edge = event; synchronous to clk.
- `mask_we`  in  1  write strobe for enable mask.
- `mask_data`  in  8  new mask value; bit i = 1 enables source i.
- `int_ack`  in  8  one-cycle acknowledge pulse from the control interface; bit i clears source i.
- `int_out`  out  8  pending & mask, forced 0 during hold-off; feeds control-interface `int_in`.
- `overflow`  out  8  sticky; bit i = event i arrived while already pending.
- `active`  out  1  1 when state is ACTIVE.

## Operation
- Reset values: `src_d` = 0, `pending` = 0, `overflow` = 0, `mask` = 8'hFF, state = IDLE, hold-off counter = 0, `int_out` = 0, `active` = 0.
- Edge detect: `rise = src_event & ~src_d`; `src_d <= src_event` every cycle. Because `src_d` resets to 0, a line already high when reset releases produces one event.
- Per bit i, updated each clock:
  - `rise[i]` = 1: `pending[i]` <= 1. Set wins over a simultaneous `int_ack[i]`.
  - `int_ack[i]` = 1 and `rise[i]` = 0: `pending[i]` <= 0.
  - `rise[i]` = 1, `pending[i]` = 1 and `int_ack[i]` = 0: `overflow[i]` <= 1.
  - `int_ack[i]` = 1: `overflow[i]` <= 0. Ack wins over a simultaneous overflow set.
- Masked sources still latch `pending` and `overflow`; they only leave `int_out`. Unmasking an already-pending bit presents it immediately.
- Mask: `mask_we` = 1 loads `mask_data` at the clock edge; it takes effect on `int_out` from the next cycle.
- `int_out = (state == HOLDOFF) ? 8'h00 : (pending & mask)`. This is combinational from registers only, with no input-to-output path.
- State machine IDLE / ACTIVE / HOLDOFF:
  - IDLE -> ACTIVE when `(pending & mask)` is nonzero.
  - ACTIVE -> IDLE when `(pending & mask)` becomes zero without any ack.
  - IDLE or ACTIVE with `int_ack` nonzero and `HOLDOFF` > 0 -> HOLDOFF; the counter loads `HOLDOFF` - 1.
  - With `HOLDOFF` = 0, an ack causes no state change beyond the normal IDLE/ACTIVE evaluation.
  - HOLDOFF: the counter decrements each cycle. When the counter is 0, go to ACTIVE if next `(pending & mask)` is nonzero, else IDLE.
  - An ack during HOLDOFF clears bits but does not reload the counter.
  - `mask_we` during HOLDOFF updates the mask only.
- Counter is 16 bits; no wrap is possible because it only loads `HOLDOFF` - 1 and stops at 0.

## Timing
- Event latency: `src_event` rises and is first sampled high at edge N. `pending` and `int_out` reflect it after edge N. `active` = 1 after edge N+1.
- Ack: `int_ack` is high for the cycle before edge M. After edge M the bit is cleared and state = HOLDOFF, so `int_out` = 0 for exactly `HOLDOFF` cycles (edges M..M+HOLDOFF-1 outputs). The vector is valid again after edge M+HOLDOFF.
- Events arriving during hold-off are latched and appear when hold-off ends.
- A width-1 `src_event` pulse is sufficient. A held-high line yields a single event until it falls and rises again.
- Reset asserted mid-operation (any state) returns every register to its reset value at that edge. `int_out` = 0 in the following cycle.

## Test plan
- Reset, then pulse `src_event` = 8'h04 for 1 cycle -> after that edge `int_out` = 8'h04; one cycle later `active` = 1; `overflow` = 0.
- With `HOLDOFF` = 4, bit 2 pending, pulse `int_ack` = 8'h04 -> `int_out` = 0 for 4 cycles, state returns to IDLE, `active` = 0. Inject `src_event` = 8'h01 during hold-off -> `int_out` = 8'h01 exactly on the 5th cycle.
- Two rises on bit 7 with no ack -> `pending[7]` = 1, `overflow` = 8'h80. Then `int_ack` = 8'h80 -> `pending` = 0, `overflow` = 0.
- Same-cycle `rise[3]` and `int_ack[3]` with bit 3 pending -> `pending[3]` stays 1, `overflow[3]` = 0, hold-off entered, `int_out` = 8'h08 after hold-off.
- `mask_we` with `mask_data` = 8'h00, then event 8'h10 -> `int_out` = 0, `active` = 0, `pending[4]` = 1. Write mask 8'hFF -> `int_out` = 8'h10 the next cycle.
- Assert `reset` during HOLDOFF with `pending` = 8'hF0 -> `int_out` = 0, `overflow` = 0, mask = 8'hFF, a new event is accepted immediately after reset release.
